// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the PC, handshakes with a variable-latency instruction
// memory and feeds the IF/ID register, buffering one word across hazard stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_load,
  output logic [31:0] id_inst,
  output logic [31:0] id_pcplus4,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] redir_pc_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;

  // A request is outstanding whenever the FSM owns the memory port.
  assign imem_req   = (state_q == S_REQ) || (state_q == S_DISCARD);
  assign fetch_busy = (state_q == S_REQ) || (state_q == S_DISCARD);
  assign imem_addr  = pc_q;

  // Next-state and IF/ID drive; redirect always wins over stall_f and ready.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc4_d  = buf_pc4_q;
    tgt_d      = tgt_q;
    id_load    = 1'b0;
    id_inst    = 32'h0000_0000;
    id_pcplus4 = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          id_load = 1'b1;
          if (imem_ready) begin
            pc_d = redir_pc_s;
          end else begin
            tgt_d   = redir_pc_s;
            state_d = S_DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4_s;
          if (stall_f) begin
            buf_inst_d = imem_rdata;
            buf_pc4_d  = pc_plus4_s;
            state_d    = S_HOLD;
          end else begin
            id_load    = 1'b1;
            id_inst    = imem_rdata;
            id_pcplus4 = pc_plus4_s;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          id_load = 1'b1;
          pc_d    = redir_pc_s;
          state_d = S_REQ;
        end else if (!stall_f) begin
          id_load    = 1'b1;
          id_inst    = buf_inst_q;
          id_pcplus4 = buf_pc4_q;
          state_d    = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DISCARD: begin
        // The old address stays on the bus until memory accepts it; its data is dropped.
        if (redirect) begin
          id_load = 1'b1;
          tgt_d   = redir_pc_s;
        end else begin
          tgt_d = tgt_q;
        end
        if (imem_ready) begin
          pc_d    = redirect ? redir_pc_s : tgt_q;
          state_d = S_REQ;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      buf_inst_q <= 32'h0000_0000;
      buf_pc4_q  <= 32'h0000_0000;
      tgt_q      <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc4_q  <= buf_pc4_d;
      tgt_q      <= tgt_d;
    end
  end

endmodule
